// File: rtl/rom_loader.sv
// Streams a DEPTH-word image into a program memory from address 0 upward,
// tracking the accepted word count and a 16-bit additive checksum.
module rom_loader #(
  parameter int AW    = 9,
  parameter int DW    = 8,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic [15:0]   checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   index_q, index_d;
  logic [AW:0]     count_q, count_d;
  logic [15:0]     checksum_q, checksum_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          index_d    = '0;
          count_d    = '0;
          checksum_d = '0;
        end
      end
      LOAD: begin
        // abort wins over a word presented on the same edge
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          mem_we_d   = 1'b1;
          mem_addr_d = index_q;
          mem_data_d = s_data;
          count_d    = count_q + (AW+1)'(1);
          checksum_d = checksum_q + 16'(s_data);
          if (index_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            index_d = index_q + AW'(1);
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = LOAD;
          index_d    = '0;
          count_d    = '0;
          checksum_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      index_q    <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign s_ready  = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign count    = count_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomised bench for rom_loader: every cycle is compared against a model that
// keeps the accepted words of the current load as a queue.
module tb_rom_loader;
  localparam int AW = 9, DW = 8, DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW:0]   count;
  logic [15:0]   checksum;

  rom_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .count(count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0 = idle, 1 = loading, 2 = image complete
  int             mode = 0;
  logic [DW-1:0]  words[$];
  bit             exp_we = 0;
  int unsigned    exp_addr = 0, exp_data = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned word_sum();
    int unsigned s = 0;
    foreach (words[i]) s += words[i];
    return s % 65536;
  endfunction

  task automatic model_edge(input bit st, input bit ab, input bit v, input logic [DW-1:0] d, input bit rn);
    exp_we = 0;
    if (!rn) begin
      mode = 0; words.delete(); exp_addr = 0; exp_data = 0;
    end else if (mode == 0) begin
      if (st) begin mode = 1; words.delete(); end
    end else if (mode == 1) begin
      if (ab) mode = 0;
      else if (v) begin
        exp_we = 1; exp_addr = words.size(); exp_data = d;
        words.push_back(d);
        if (words.size() == DEPTH) mode = 2;
      end
    end else begin
      if (ab) mode = 0;
      else if (st) begin mode = 1; words.delete(); end
    end
  endtask

  // one clock: drive inputs, take the edge, then compare every output
  task automatic step(input bit st, input bit ab, input bit v, input logic [DW-1:0] d, input bit rn);
    start = st; abort = ab; s_valid = v; s_data = d; rst_n = rn;
    @(posedge clk);
    model_edge(st, ab, v, d, rn);
    #1;
    check_eq("s_ready", s_ready, (mode == 1));
    check_eq("busy", busy, (mode == 1));
    check_eq("done", done, (mode == 2));
    check_eq("mem_we", mem_we, exp_we);
    check_eq("mem_addr", mem_addr, exp_addr);
    check_eq("mem_data", mem_data, exp_data);
    check_eq("count", count, words.size());
    check_eq("checksum", checksum, word_sum());
    if (exp_we) $display("write addr=%0d data=0x%02h count=%0d", mem_addr, mem_data, count);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 1);
  endtask

  task automatic load_pattern(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = words.size();
      step(0, 0, 1, 8'(k), 1);
    end
  endtask

  task automatic load_random(input int n);
    int acc = 0;
    for (int i = 0; i < 4 * n && acc < n; i++) begin
      bit v = ($urandom_range(0, 3) != 0);
      step(0, 0, v, 8'($urandom), 1);
      if (v) acc++;
    end
  endtask

  initial begin
    start = 0; abort = 0; s_valid = 0; s_data = '0; rst_n = 0;
    for (int i = 0; i < 3; i++) step(0, 0, $urandom_range(0, 1), 8'($urandom), 0);
    idle_cycles(2);

    // full load with data = address
    step(1, 0, 0, 8'h00, 1);
    load_pattern(DEPTH);
    check_eq("full_count", count, 512);
    check_eq("full_checksum", checksum, 16'hFF00);
    check_eq("full_done", done, 1);

    // held valid while complete
    for (int i = 0; i < 20; i++) step(0, 0, 1, 8'($urandom), 1);
    check_eq("stall_count", count, 512);

    // restart from DONE, gapped valid pattern 1,0,0
    step(1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 30; i++) step(0, 0, (i % 3) == 0, 8'h5A, 1);
    check_eq("gap_count", count, 10);
    check_eq("gap_checksum", checksum, 16'h0384);

    // abort at 100 words, then a clean reload
    step(0, 1, 0, 8'h00, 1);
    idle_cycles(1);
    step(1, 0, 0, 8'h00, 1);
    load_random(100);
    step(0, 1, 1, 8'hAA, 1);
    check_eq("abort_count", count, 100);
    check_eq("abort_done", done, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom), 1);
    step(1, 0, 0, 8'h00, 1);
    load_pattern(1);
    check_eq("restart_addr", mem_addr, 0);
    load_random(DEPTH - 1);
    load_random(DEPTH);
    check_eq("restart_count", count, 512);

    // reset at word 37, valid without start is ignored
    step(1, 0, 0, 8'h00, 1);
    load_random(37);
    step(0, 0, 1, 8'h77, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom), 1);

    // start inside LOAD is ignored
    step(1, 0, 0, 8'h00, 1);
    load_random(5);
    step(1, 0, 1, 8'h33, 1);
    load_random(DEPTH);
    load_random(DEPTH);
    step(1, 0, 1, 8'h44, 1);
    step(0, 0, 1, 8'h55, 1);
    check_eq("reload_addr", mem_addr, 0);

    // random control soak
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1,
           $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 999) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
# rom_loader

Fills a DEPTH-word program memory in strict address order from a valid/ready word stream. It is the write-side counterpart of the free-running ROM address generator: that block reads a 512-word image from address 0 upward; this block writes that image from address 0 upward. It drives the memory write port (we/addr/data) and keeps a word count and a 16-bit additive checksum, so software can confirm the image before the address generator is released from reset.

## Interface
- AW, 9: memory address width.
- DW, 8: data word width.
- DEPTH, 512: words per image; must be ≤ 2^AW.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load.
- abort  in  1  single-cycle pulse; cancels a load in progress.
- s_valid  in  1  input word valid.
- s_data  in  DW  input word.
- s_ready  out  1  loader accepts a word; equals (state==LOAD).
- mem_we  out  1  registered memory write enable.
- mem_addr  out  AW  registered write address.
- mem_data  out  DW  registered write data.
- busy  out  1  state==LOAD.
- done  out  1  state==DONE; full image written.
- count  out  AW+1  words accepted in the current or last load.
- checksum  out  16  sum of zero-extended accepted words, mod 2^16.

## Operation
- State IDLE:
  - start → LOAD.
  - Write index, count and checksum clear to 0 on the same edge.
- State LOAD:
  - A word is accepted on an edge where s_valid && s_ready.
  - On acceptance:
    - mem_we=1, mem_addr=index, mem_data=s_data, all registered.
    - index+1; count+1; checksum += {0,s_data}, truncated to 16 bits.
  - With no acceptance, mem_we=0 on the next cycle. mem_addr and mem_data hold their values.
  - Acceptance of word DEPTH-1 → DONE on the same edge. The index does not wrap into a second pass.
  - abort → IDLE. Any acceptance on that same edge is ignored: no write, no count update. done stays 0. count and checksum keep their partial values.
  - start while in LOAD is ignored.
  - abort takes priority over start.
- State DONE:
  - done=1 and s_ready=0.
  - count=DEPTH; checksum is frozen.
  - start → LOAD: clears index, count and checksum and restarts at address 0.
  - abort → IDLE: done drops.
- Synchronous reset on any edge with rst=0, including mid-load:
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_data=0.
  - count=0, checksum=0.
  - busy=0, done=0, s_ready=0.
  - Partially written memory contents are not restored.
- Width rules:
  - count is AW+1 bits so DEPTH=512 is representable.
  - The write index is AW bits.
  - The checksum adder is 16 bits and wraps silently.

## Timing
- s_ready is high the cycle after start is sampled. The first acceptance can occur on the following edge.
- Write latency is one cycle: a word accepted at edge k appears on mem_we/mem_addr/mem_data in the cycle after edge k.
- Back-to-back acceptance sustains 1 word/clock.
- Last word:
  - On the edge that accepts word DEPTH-1, done rises and busy/s_ready fall.
  - The final write (mem_addr=DEPTH-1) is visible in the same cycle done first reads 1.
- count and checksum update on the acceptance edge, together with mem_we.
- s_valid with s_ready=0 is held off. No data is lost and the upstream source must hold the word.

## Test plan
- Full load:
  - Stimulus: reset; start; 512 consecutive valid words with s_data = addr[7:0].
  - Response:
    - 512 mem_we pulses with mem_addr 0..511 and matching data.
    - done=1 after the last word; count=512; checksum=0xFF00 (2×32640 mod 2^16).
- Gapped valid:
  - Stimulus: s_valid toggled 1,0,0,1,… over 10 words of value 0x5A.
  - Response: mem_we is high only after accepting cycles; addresses are contiguous 0..9; checksum=0x0384.
- Abort mid-load:
  - Stimulus: abort after 100 words; then start and load 512 words.
  - Response:
    - After abort: IDLE, done=0, count=100.
    - After restart: first write is at addr 0; count ends at 512.
- Reset mid-load:
  - Stimulus: rst=0 for 1 cycle at word 37.
  - Response: next cycle all outputs are 0 and s_ready=0. Subsequent s_valid produces no writes until start.
- Restart from DONE / ignored start:
  - Stimulus: start pulsed in LOAD at word 5 (ignored), then a full load; then start from DONE.
  - Response: no address skip; count and checksum clear and the reload begins at addr 0.
- Stall in DONE:
  - Stimulus: s_valid=1 held in DONE for 20 cycles.
  - Response: s_ready=0, mem_we=0, count stays 512.
